serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package subtractor_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: Y = A - B - bin, with bout the borrow out of this bit.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic bin,
  output logic Y,
  output logic bout
);

  // Difference bit and borrow generation/propagation
  assign Y    = A ^ B ^ bin;
  assign bout = (~A & B) | (~(A ^ B) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, result a-b mod 2^WIDTH.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_e       state;
  sub_state_e       state_nx;
  logic             busy_nx;
  logic             done_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;

  logic             bit_d;
  logic             bit_bout;
  logic             accept;
  logic             last_bit;

  // Per-bit arithmetic on the current LSBs of the operand registers
  full_subtractor u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .bin  (borrow_q),
    .Y    (bit_d),
    .bout (bit_bout)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == CNT_LAST);
  assign res_nx   = {bit_d, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)    state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    if (state_nx == RUN)  busy_nx = 1'b1;
    if (state_nx == DONE) done_nx = 1'b1;
  end

  // Registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Operand/result shift registers, borrow chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= res_nx;
      borrow_q <= bit_bout;
      // Counter parks on the last index rather than wrapping
      if (!last_bit) cnt <= cnt + CNT_W'(1);
    end
  end

  // Visible result, updated only as the final bit is processed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else if (last_bit) begin
      diff       <= res_nx;
      borrow_out <= bit_bout;
      zero       <= (res_nx == '0);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor with directed vectors.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    int d;
    int br;
    int z;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
  logic         busy;
  logic         done;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   m_diff   = 0;
  int   m_br     = 0;
  int   m_z      = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse, checks results hold during RUN
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_diff = 0;
      m_br   = 0;
      m_z    = 0;
    end else if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("diff", int'(diff), e.d);
        check("borrow_out", int'(borrow_out), e.br);
        check("zero", int'(zero), e.z);
        m_diff = e.d;
        m_br   = e.br;
        m_z    = e.z;
      end
    end else if (busy) begin
      check("hold_diff", int'(diff), m_diff);
      check("hold_borrow", int'(borrow_out), m_br);
      check("hold_zero", int'(zero), m_z);
    end
  end

  // Present one operation; returns #1 after the accepting edge with junk on a/b
  task automatic issue(input int av, input int bv, input int d, input int br, input int z);
    exp_t e;
    e.d  = d;
    e.br = br;
    e.z  = z;
    sb.push_back(e);
    start = 1'b1;
    a     = W'(av);
    b     = W'(bv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Count edges until done, starting from k0 edges already elapsed
  task automatic wait_done(input int k0, input int lat_exp, input string name);
    int k;
    k = k0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, k, lat_exp);
  endtask

  task automatic step_check_pulse(input string name);
    @(posedge clk);
    #1;
    check(name, int'(done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;

    // Reset state
    #2;
    check("rst_diff", int'(diff), 0);
    check("rst_borrow", int'(borrow_out), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    #10;
    rst_n = 1'b1;

    // First start accepted on the first edge after reset release
    issue(100, 37, 63, 0, 0);
    check("busy_run", int'(busy), 1);
    wait_done(0, 8, "lat_100_37");
    step_check_pulse("pulse_100_37");
    check("idle_busy", int'(busy), 0);

    issue(5, 10, 251, 1, 0);
    wait_done(0, 8, "lat_5_10");
    step_check_pulse("pulse_5_10");

    issue(8'h5A, 8'h5A, 0, 0, 1);
    wait_done(0, 8, "lat_eq");
    step_check_pulse("pulse_eq");

    issue(0, 255, 1, 1, 0);
    wait_done(0, 8, "lat_0_255");
    step_check_pulse("pulse_0_255");

    issue(255, 0, 255, 0, 0);
    wait_done(0, 8, "lat_255_0");
    step_check_pulse("pulse_255_0");

    issue(128, 127, 1, 0, 0);
    wait_done(0, 8, "lat_128_127");
    step_check_pulse("pulse_128_127");

    // start pulsed mid-RUN with different operands must be ignored
    d0 = done_cnt;
    issue(200, 1, 199, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = W'(3);
    b     = W'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, 8, "lat_ignore");
    step_check_pulse("pulse_ignore");
    repeat (12) @(posedge clk);
    #1;
    check("ignore_one_done", done_cnt - d0, 1);
    check("ignore_idle", int'(busy), 0);

    // start held high across done: back-to-back operations
    d0 = done_cnt;
    begin
      exp_t e1;
      exp_t e2;
      e1.d = 5;   e1.br = 0; e1.z = 0;
      e2.d = 251; e2.br = 1; e2.z = 0;
      sb.push_back(e1);
      sb.push_back(e2);
    end
    start = 1'b1;
    a     = W'(7);
    b     = W'(2);
    @(posedge clk);
    #1;
    a = W'(2);
    b = W'(7);
    wait_done(0, 8, "lat_b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_drop", int'(done), 0);
    wait_done(1, 9, "b2b_spacing");
    step_check_pulse("pulse_b2b");
    check("b2b_two_done", done_cnt - d0, 2);

    // Reset during RUN aborts with no done pulse
    d0    = done_cnt;
    start = 1'b1;
    a     = W'(50);
    b     = W'(20);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow_out), 0);
    check("abort_zero", int'(zero), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    #20;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", int'(busy), 0);

    // Fresh operation after the abort
    issue(50, 20, 30, 0, 0);
    wait_done(0, 8, "lat_after_abort");
    step_check_pulse("pulse_after_abort");

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
